// File: rtl/mips_pipe_pkg.sv
// Shared types and helpers for the MIPS pipeline interlock.
// Provides the long-latency FSM state type, REG_ZERO and select-width helper.
package mips_pipe_pkg;

  typedef enum logic {
    LL_IDLE,
    LL_BUSY
  } ll_state_t;

  localparam int REG_ZERO = 0;

  // Select encoding: 0 = register file, k+1 = forwarding source k.
  function automatic int fsel_w(int num_fwd);
    return $clog2(num_fwd + 1);
  endfunction

endpackage

// File: rtl/mips_pipe_interlock_fwd.sv
// Priority forwarding match of one operand against all sources.
// Ports: reg_i operand, regWrite_i/dst_i per source, sel_o (0=RF, k+1=src k).
module mips_fwd_select
  import mips_pipe_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_FWD    = 2,
  parameter int FSEL_W     = 2
) (
  input  logic [REG_ADDR_W-1:0]         reg_i,
  input  logic [NUM_FWD-1:0]            regWrite_i,
  input  logic [NUM_FWD*REG_ADDR_W-1:0] dst_i,
  output logic [FSEL_W-1:0]             sel_o
);

  // Scan oldest to youngest so the youngest match overwrites.
  always_comb begin
    sel_o = '0;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (regWrite_i[k] &&
          dst_i[k*REG_ADDR_W +: REG_ADDR_W] != REG_ADDR_W'(REG_ZERO) &&
          dst_i[k*REG_ADDR_W +: REG_ADDR_W] == reg_i) begin
        sel_o = FSEL_W'(k + 1);
      end
    end
  end

endmodule

// File: rtl/mips_pipe_interlock.sv
// Hazard, forwarding and scoreboard unit with one-deep mul/div issue FSM.
// In: ID/EX operand info, forwarding sources, ll_done. Out: stall, llIssue,
// four forward selects, pending scoreboard, sticky llTimeout, stallCycles.
module mips_pipe_interlock
  import mips_pipe_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int NUM_REGS    = 32,
  parameter int NUM_FWD     = 2,
  parameter int LL_MAX_LAT  = 34,
  parameter int STALL_CNT_W = 16,
  localparam int FSEL_W     = fsel_w(NUM_FWD)
) (
  input  logic                          clock__i,
  input  logic                          reset__i,
  input  logic [REG_ADDR_W-1:0]         id_rs__i,
  input  logic [REG_ADDR_W-1:0]         id_rt__i,
  input  logic                          id_useRs__i,
  input  logic                          id_useRt__i,
  input  logic                          id_branch__i,
  input  logic                          id_llOp__i,
  input  logic [REG_ADDR_W-1:0]         id_llDst__i,
  input  logic                          id_flush__i,
  input  logic [REG_ADDR_W-1:0]         ex_rs__i,
  input  logic [REG_ADDR_W-1:0]         ex_rt__i,
  input  logic                          ex_regWrite__i,
  input  logic                          ex_memRead__i,
  input  logic [REG_ADDR_W-1:0]         ex_dst__i,
  input  logic [NUM_FWD-1:0]            fwd_regWrite__i,
  input  logic [NUM_FWD-1:0]            fwd_isLoad__i,
  input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_dst__i,
  input  logic                          ll_done__i,
  output logic                          stall__o,
  output logic                          llIssue__o,
  output logic [FSEL_W-1:0]             fwdAluA__o,
  output logic [FSEL_W-1:0]             fwdAluB__o,
  output logic [FSEL_W-1:0]             fwdEqA__o,
  output logic [FSEL_W-1:0]             fwdEqB__o,
  output logic [NUM_REGS-1:0]           pending__o,
  output logic                          llTimeout__o,
  output logic [STALL_CNT_W-1:0]        stallCycles__o
);

  localparam int BCNT_W = $clog2(LL_MAX_LAT + 1);
  localparam logic [REG_ADDR_W-1:0] RZ = REG_ADDR_W'(REG_ZERO);

  ll_state_t               state_q, state_d;
  logic [REG_ADDR_W-1:0]   llDst_q, llDst_d;
  logic [BCNT_W-1:0]       busyCnt_q, busyCnt_d;
  logic [NUM_REGS-1:0]     pending_q, pending_d;
  logic                    timeout_q, timeout_d;
  logic [STALL_CNT_W-1:0]  stallCnt_q, stallCnt_d;

  logic [FSEL_W-1:0] selAluA, selAluB, selEqA, selEqB;

  // Only source 0 can still hold an in-flight load.
  logic unused_isload;
  assign unused_isload = ^fwd_isLoad__i;

  mips_fwd_select #(
    .REG_ADDR_W(REG_ADDR_W), .NUM_FWD(NUM_FWD), .FSEL_W(FSEL_W)
  ) u_fwd_alu_a (
    .reg_i(ex_rs__i), .regWrite_i(fwd_regWrite__i),
    .dst_i(fwd_dst__i), .sel_o(selAluA)
  );

  mips_fwd_select #(
    .REG_ADDR_W(REG_ADDR_W), .NUM_FWD(NUM_FWD), .FSEL_W(FSEL_W)
  ) u_fwd_alu_b (
    .reg_i(ex_rt__i), .regWrite_i(fwd_regWrite__i),
    .dst_i(fwd_dst__i), .sel_o(selAluB)
  );

  mips_fwd_select #(
    .REG_ADDR_W(REG_ADDR_W), .NUM_FWD(NUM_FWD), .FSEL_W(FSEL_W)
  ) u_fwd_eq_a (
    .reg_i(id_rs__i), .regWrite_i(fwd_regWrite__i),
    .dst_i(fwd_dst__i), .sel_o(selEqA)
  );

  mips_fwd_select #(
    .REG_ADDR_W(REG_ADDR_W), .NUM_FWD(NUM_FWD), .FSEL_W(FSEL_W)
  ) u_fwd_eq_b (
    .reg_i(id_rt__i), .regWrite_i(fwd_regWrite__i),
    .dst_i(fwd_dst__i), .sel_o(selEqB)
  );

  // Combinational outputs are held at zero while reset is asserted.
  assign fwdAluA__o = reset__i ? '0 : selAluA;
  assign fwdAluB__o = reset__i ? '0 : selAluB;
  assign fwdEqA__o  = reset__i ? '0 : selEqA;
  assign fwdEqB__o  = reset__i ? '0 : selEqB;

  logic rsV, rtV;
  logic [REG_ADDR_W-1:0] src0Dst;
  logic hzLoadUse, hzBrEx, hzBrMem, hzRaw, hzWaw, hzStruct;
  logic stall, issue;

  assign rsV     = id_useRs__i && (id_rs__i != RZ);
  assign rtV     = id_useRt__i && (id_rt__i != RZ);
  assign src0Dst = fwd_dst__i[REG_ADDR_W-1:0];

  assign hzLoadUse = ex_memRead__i &&
                     ((rsV && ex_dst__i == id_rs__i) ||
                      (rtV && ex_dst__i == id_rt__i));
  assign hzBrEx    = id_branch__i && ex_regWrite__i &&
                     ((rsV && ex_dst__i == id_rs__i) ||
                      (rtV && ex_dst__i == id_rt__i));
  assign hzBrMem   = id_branch__i && fwd_isLoad__i[0] &&
                     ((rsV && src0Dst == id_rs__i) ||
                      (rtV && src0Dst == id_rt__i));
  assign hzRaw     = (rsV && pending_q[id_rs__i]) ||
                     (rtV && pending_q[id_rt__i]);
  assign hzWaw     = id_llOp__i && pending_q[id_llDst__i];
  assign hzStruct  = id_llOp__i && (state_q != LL_IDLE);

  assign stall = ~reset__i &
                 (hzLoadUse | hzBrEx | hzBrMem | hzRaw | hzWaw | hzStruct);
  assign issue = ~reset__i & id_llOp__i & ~stall & ~id_flush__i &
                 (state_q == LL_IDLE);

  assign stall__o       = stall;
  assign llIssue__o     = issue;
  assign pending__o     = pending_q;
  assign llTimeout__o   = timeout_q;
  assign stallCycles__o = stallCnt_q;

  logic [NUM_REGS-1:0] setM, clrM;
  logic [BCNT_W-1:0]   busyInc;

  assign busyInc = busyCnt_q + BCNT_W'(1);

  always_comb begin
    state_d    = state_q;
    llDst_d    = llDst_q;
    busyCnt_d  = busyCnt_q;
    timeout_d  = timeout_q;
    stallCnt_d = stallCnt_q;
    setM       = '0;
    clrM       = '0;
    unique case (state_q)
      LL_IDLE: begin
        if (issue) begin
          state_d   = LL_BUSY;
          llDst_d   = id_llDst__i;
          busyCnt_d = '0;
          if (id_llDst__i != RZ) setM[id_llDst__i] = 1'b1;
        end
      end
      LL_BUSY: begin
        busyCnt_d = busyInc;
        if (ll_done__i) begin
          clrM[llDst_q] = 1'b1;
          state_d       = LL_IDLE;
        end else if (busyInc == BCNT_W'(LL_MAX_LAT)) begin
          clrM[llDst_q] = 1'b1;
          timeout_d     = 1'b1;
          state_d       = LL_IDLE;
        end
      end
      default: state_d = LL_IDLE;
    endcase
    // Clear first, then set: a set wins on the same register.
    pending_d = (pending_q & ~clrM) | setM;
    if (stall && !(&stallCnt_q)) begin
      stallCnt_d = stallCnt_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clock__i) begin
    if (reset__i) begin
      state_q    <= LL_IDLE;
      llDst_q    <= '0;
      busyCnt_q  <= '0;
      pending_q  <= '0;
      timeout_q  <= 1'b0;
      stallCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      llDst_q    <= llDst_d;
      busyCnt_q  <= busyCnt_d;
      pending_q  <= pending_d;
      timeout_q  <= timeout_d;
      stallCnt_q <= stallCnt_d;
    end
  end

endmodule
